display_timings_multimode: RTL and testbench

Multi-mode display timing generator: run-time selection among NUM_MODES parameterised video modes, chosen by a valid/ready request. Switches only at a frame boundary, with a programmable blanking gap during which the pixel clock source may be retuned. Sits between display_clocks and the pattern/TMDS path (dvi_generator), replacing a single fixed-mode timing generator.

---
 rtl/display_timings_multimode.sv | 242 ++++++++++++++++++++++++
 tb/tb_display_timings_multimode.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/display_timings_multimode.sv
// Multi-mode video timing generator: run-time mode selection, switching only at frame end with a retune gap.
// Optional DISPLAY_TIMINGS_FRAME_CNT_EN adds the 16-bit o_frame_cnt output.
module display_timings_multimode #(
   parameter int                      NUM_MODES     = 4,
   parameter int                      CW            = 12,
   parameter logic [16*NUM_MODES-1:0] H_RES_LIST    = {16'd1920, 16'd1280, 16'd800, 16'd640},
   parameter logic [16*NUM_MODES-1:0] H_FP_LIST     = {16'd88, 16'd110, 16'd40, 16'd16},
   parameter logic [16*NUM_MODES-1:0] H_SYNC_LIST   = {16'd44, 16'd40, 16'd128, 16'd96},
   parameter logic [16*NUM_MODES-1:0] H_BP_LIST     = {16'd148, 16'd220, 16'd88, 16'd48},
   parameter logic [16*NUM_MODES-1:0] V_RES_LIST    = {16'd1080, 16'd720, 16'd600, 16'd480},
   parameter logic [16*NUM_MODES-1:0] V_FP_LIST     = {16'd4, 16'd5, 16'd1, 16'd10},
   parameter logic [16*NUM_MODES-1:0] V_SYNC_LIST   = {16'd5, 16'd5, 16'd4, 16'd2},
   parameter logic [16*NUM_MODES-1:0] V_BP_LIST     = {16'd36, 16'd20, 16'd23, 16'd33},
   parameter logic [2*NUM_MODES-1:0]  POL_LIST      = 8'b11_11_11_00,
   parameter int                      DEFAULT_MODE  = 0,
   parameter int                      SWITCH_CYCLES = 1024
) (
   input  logic          i_pixclk,
   input  logic          i_rst_n,
   input  logic [1:0]    i_mode,
   input  logic          i_mode_valid,
   output logic          o_mode_ready,
   output logic          o_mode_err,
   output logic          o_mode_done,
   output logic [1:0]    o_mode,
   output logic          o_switching,
   output logic          o_hs,
   output logic          o_vs,
   output logic          o_de,
   output logic          o_frame,
   output logic          o_line,
   output logic [CW-1:0] o_h,
   output logic [CW-1:0] o_v
`ifdef DISPLAY_TIMINGS_FRAME_CNT_EN
   ,
   output logic [15:0]   o_frame_cnt
`endif
);

   localparam int   SW_W       = $clog2(SWITCH_CYCLES + 1);
   localparam logic DEF_HS_OFF = !POL_LIST[2*DEFAULT_MODE];
   localparam logic DEF_VS_OFF = !POL_LIST[2*DEFAULT_MODE+1];

   if (NUM_MODES < 1 || NUM_MODES > 4) begin : g_bad_modes
      $error("NUM_MODES must be in 1..4");
   end
   if (CW < 1 || CW > 16) begin : g_bad_cw
      $error("CW must be in 1..16");
   end
   if (DEFAULT_MODE < 0 || DEFAULT_MODE >= NUM_MODES) begin : g_bad_default
      $error("DEFAULT_MODE out of range");
   end
   if (SWITCH_CYCLES < 1) begin : g_bad_switch
      $error("SWITCH_CYCLES must be at least 1");
   end
   for (genvar m = 0; m < NUM_MODES; m++) begin : g_chk
      localparam int HT = int'(H_RES_LIST[16*m +: 16]) + int'(H_FP_LIST[16*m +: 16])
                        + int'(H_SYNC_LIST[16*m +: 16]) + int'(H_BP_LIST[16*m +: 16]);
      localparam int VT = int'(V_RES_LIST[16*m +: 16]) + int'(V_FP_LIST[16*m +: 16])
                        + int'(V_SYNC_LIST[16*m +: 16]) + int'(V_BP_LIST[16*m +: 16]);
      if (HT >= 2**CW || VT >= 2**CW) begin : g_bad_total
         $error("mode totals must fit in CW bits");
      end
   end

   typedef enum logic [1:0] {S_RUN = 2'd0, S_PEND = 2'd1, S_SWITCH = 2'd2} state_e;

   typedef struct packed {
      logic [CW-1:0] h_res;
      logic [CW-1:0] h_ss;
      logic [CW-1:0] h_se;
      logic [CW-1:0] v_res;
      logic [CW-1:0] v_ss;
      logic [CW-1:0] v_se;
      logic          hpol;
      logic          vpol;
   } timing_t;

   function automatic logic [CW-1:0] fld(input logic [16*NUM_MODES-1:0] list, input logic [1:0] m);
      return CW'(list[16*m +: 16]);
   endfunction

   function automatic timing_t mode_timing(input logic [1:0] m);
      timing_t t;
      t.h_res = fld(H_RES_LIST, m);
      t.h_ss  = t.h_res + fld(H_FP_LIST, m);
      t.h_se  = t.h_ss + fld(H_SYNC_LIST, m);
      t.v_res = fld(V_RES_LIST, m);
      t.v_ss  = t.v_res + fld(V_FP_LIST, m);
      t.v_se  = t.v_ss + fld(V_SYNC_LIST, m);
      t.hpol  = POL_LIST[2*m];
      t.vpol  = POL_LIST[2*m+1];
      return t;
   endfunction

   function automatic logic [CW-1:0] h_total(input logic [1:0] m);
      return fld(H_RES_LIST, m) + fld(H_FP_LIST, m) + fld(H_SYNC_LIST, m) + fld(H_BP_LIST, m);
   endfunction

   function automatic logic [CW-1:0] v_total(input logic [1:0] m);
      return fld(V_RES_LIST, m) + fld(V_FP_LIST, m) + fld(V_SYNC_LIST, m) + fld(V_BP_LIST, m);
   endfunction

   state_e        state_q, state_d;
   logic [1:0]    mode_q, mode_d, pend_q, pend_d;
   logic [SW_W-1:0] sw_cnt_q, sw_cnt_d;
   logic          active_q, active_d;
   logic          ready_q, ready_d, err_q, err_d, done_q, done_d, sw_q, sw_d;
   logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d, frame_q, frame_d, line_q, line_d;
   logic [CW-1:0] h_q, h_d, v_q, v_d;
   logic [CW-1:0] cur_htot, cur_vtot;
   logic          accept, req_ok, last_px;
   timing_t       tn;
`ifdef DISPLAY_TIMINGS_FRAME_CNT_EN
   logic [15:0]   cnt_q, cnt_d;
`endif

   assign cur_htot = h_total(mode_q);
   assign cur_vtot = v_total(mode_q);
   assign accept   = i_mode_valid && ready_q;
   assign req_ok   = int'(i_mode) < NUM_MODES;
   assign last_px  = active_q && (h_q == cur_htot - CW'(1)) && (v_q == cur_vtot - CW'(1));

   always_ff @(posedge i_pixclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= S_RUN;
         mode_q   <= 2'(DEFAULT_MODE);
         pend_q   <= 2'(DEFAULT_MODE);
         sw_cnt_q <= '0;
         active_q <= 1'b0;
         ready_q  <= 1'b0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
         sw_q     <= 1'b0;
         hs_q     <= DEF_HS_OFF;
         vs_q     <= DEF_VS_OFF;
         de_q     <= 1'b0;
         frame_q  <= 1'b0;
         line_q   <= 1'b0;
         h_q      <= '0;
         v_q      <= '0;
`ifdef DISPLAY_TIMINGS_FRAME_CNT_EN
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         pend_q   <= pend_d;
         sw_cnt_q <= sw_cnt_d;
         active_q <= active_d;
         ready_q  <= ready_d;
         err_q    <= err_d;
         done_q   <= done_d;
         sw_q     <= sw_d;
         hs_q     <= hs_d;
         vs_q     <= vs_d;
         de_q     <= de_d;
         frame_q  <= frame_d;
         line_q   <= line_d;
         h_q      <= h_d;
         v_q      <= v_d;
`ifdef DISPLAY_TIMINGS_FRAME_CNT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      pend_d   = pend_q;
      sw_cnt_d = sw_cnt_q;
      case (state_q)
         S_RUN: begin
            if (accept && req_ok && (i_mode != mode_q)) begin
               pend_d  = i_mode;
               state_d = S_PEND;
            end
         end
         S_PEND: begin
            if (last_px) begin
               state_d  = S_SWITCH;
               sw_cnt_d = '0;
            end
         end
         S_SWITCH: begin
            if (sw_cnt_q == SW_W'(SWITCH_CYCLES - 1)) begin
               state_d = S_RUN;
            end else begin
               sw_cnt_d = sw_cnt_q + SW_W'(1);
            end
         end
         default: state_d = S_RUN;
      endcase
   end

   // Decodes are computed from the next pixel position so that every registered output describes one pixel.
   always_comb begin
      ready_d  = (state_d == S_RUN);
      err_d    = (state_q == S_RUN) && accept && !req_ok;
      done_d   = ((state_q == S_RUN) && accept && req_ok && (i_mode == mode_q))
              || ((state_q == S_SWITCH) && (state_d == S_RUN));
      mode_d   = ((state_q == S_SWITCH) && (state_d == S_RUN)) ? pend_q : mode_q;
      sw_d     = (state_d == S_SWITCH);
      active_d = !sw_d;
      tn       = mode_timing(sw_d ? pend_q : mode_d);
      h_d      = '0;
      v_d      = '0;
      if (active_q && !sw_d) begin
         if (h_q == cur_htot - CW'(1)) begin
            v_d = (v_q == cur_vtot - CW'(1)) ? '0 : v_q + CW'(1);
         end else begin
            h_d = h_q + CW'(1);
            v_d = v_q;
         end
      end
      de_d    = !sw_d && (h_d < tn.h_res) && (v_d < tn.v_res);
      hs_d    = (!sw_d && (h_d >= tn.h_ss) && (h_d < tn.h_se)) ? tn.hpol : !tn.hpol;
      vs_d    = (!sw_d && (v_d >= tn.v_ss) && (v_d < tn.v_se)) ? tn.vpol : !tn.vpol;
      frame_d = !sw_d && (h_d == '0) && (v_d == '0);
      line_d  = !sw_d && (h_d == '0);
`ifdef DISPLAY_TIMINGS_FRAME_CNT_EN
      cnt_d   = sw_d ? '0 : (frame_d ? cnt_q + 16'd1 : cnt_q);
`endif
   end

   assign o_mode_ready = ready_q;
   assign o_mode_err   = err_q;
   assign o_mode_done  = done_q;
   assign o_mode       = mode_q;
   assign o_switching  = sw_q;
   assign o_hs         = hs_q;
   assign o_vs         = vs_q;
   assign o_de         = de_q;
   assign o_frame      = frame_q;
   assign o_line       = line_q;
   assign o_h          = h_q;
   assign o_v          = v_q;
`ifdef DISPLAY_TIMINGS_FRAME_CNT_EN
   assign o_frame_cnt  = cnt_q;
`endif

endmodule

// File: tb/tb_display_timings_multimode.sv
// Scoreboard bench for display_timings_multimode using three small hand-sized modes and a short retune gap.
module tb_display_timings_multimode;
   localparam int CW  = 12;
   localparam int SWC = 16;
   localparam int M_RUN = 0, M_PEND = 1, M_SW = 2;

   // Mode 0: 15x8 (hs low h10..12, vs low v5..6); mode 1: 10x6; mode 2: 17x10 (hs high h12..13, vs high v6..7)
   int HR[3]  = '{8, 6, 10};
   int HF[3]  = '{2, 1, 2};
   int HSY[3] = '{3, 2, 2};
   int HB[3]  = '{2, 1, 3};
   int VR[3]  = '{4, 3, 5};
   int VF[3]  = '{1, 1, 1};
   int VSY[3] = '{2, 1, 2};
   int VB[3]  = '{1, 1, 2};
   bit HP[3]  = '{1'b0, 1'b1, 1'b1};
   bit VP[3]  = '{1'b0, 1'b1, 1'b1};
   string PH[7] = '{"reset", "mode0_run", "err_req", "same_req", "switch_to_2", "rst_in_switch", "after_rst"};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, mode_valid;
   logic [1:0]    mode_in;
   logic          mode_ready, mode_err, mode_done, switching, hs, vs, de, frame, line;
   logic [1:0]    mode_out;
   logic [CW-1:0] h, v;
`ifdef DISPLAY_TIMINGS_FRAME_CNT_EN
   logic [15:0]   frame_cnt;
`endif

   display_timings_multimode #(
      .NUM_MODES(3), .CW(CW),
      .H_RES_LIST({16'd10, 16'd6, 16'd8}), .H_FP_LIST({16'd2, 16'd1, 16'd2}),
      .H_SYNC_LIST({16'd2, 16'd2, 16'd3}), .H_BP_LIST({16'd3, 16'd1, 16'd2}),
      .V_RES_LIST({16'd5, 16'd3, 16'd4}), .V_FP_LIST({16'd1, 16'd1, 16'd1}),
      .V_SYNC_LIST({16'd2, 16'd1, 16'd2}), .V_BP_LIST({16'd2, 16'd1, 16'd1}),
      .POL_LIST(6'b11_11_00), .DEFAULT_MODE(0), .SWITCH_CYCLES(SWC)
   ) dut (
      .i_pixclk(clk), .i_rst_n(rst_n), .i_mode(mode_in), .i_mode_valid(mode_valid),
      .o_mode_ready(mode_ready), .o_mode_err(mode_err), .o_mode_done(mode_done),
      .o_mode(mode_out), .o_switching(switching), .o_hs(hs), .o_vs(vs), .o_de(de),
      .o_frame(frame), .o_line(line), .o_h(h), .o_v(v)
`ifdef DISPLAY_TIMINGS_FRAME_CNT_EN
      , .o_frame_cnt(frame_cnt)
`endif
   );

   typedef struct {
      int h, v, mode, cnt, ph;
      bit de, hs, vs, frame, line, ready, err, done, sw;
   } exp_t;

   exp_t expq[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cur_ph   = 0;

   // Reference model: frame position index plus request/switch bookkeeping.
   int mstate, mmode, mpend, mp, swc, mcnt;
   bit mactive, mready, m_err, m_done, in_rst;

   function automatic int htot(input int m);
      return HR[m] + HF[m] + HSY[m] + HB[m];
   endfunction

   function automatic int vtot(input int m);
      return VR[m] + VF[m] + VSY[m] + VB[m];
   endfunction

   task automatic model_reset();
      mstate = M_RUN; mmode = 0; mpend = 0; mp = 0; swc = 0; mcnt = 0;
      mactive = 1'b0; m_err = 1'b0; m_done = 1'b0; in_rst = 1'b1;
   endtask

   task automatic advance(input int ht, input int vt);
      if (!mactive) begin
         mp = 0;
         mactive = 1'b1;
      end else begin
         mp = (mp + 1) % (ht * vt);
      end
   endtask

   task automatic model_step();
      int ht, vt;
      ht = htot(mmode);
      vt = vtot(mmode);
      in_rst = 1'b0; m_err = 1'b0; m_done = 1'b0;
      case (mstate)
         M_RUN: begin
            if (mode_valid && mready) begin
               if (int'(mode_in) >= 3) m_err = 1'b1;
               else if (int'(mode_in) == mmode) m_done = 1'b1;
               else begin
                  mpend  = int'(mode_in);
                  mstate = M_PEND;
               end
            end
            advance(ht, vt);
         end
         M_PEND: begin
            if (mactive && mp == ht * vt - 1) begin
               mstate = M_SW;
               swc = 1;
            end else begin
               advance(ht, vt);
            end
         end
         default: begin
            if (swc == SWC) begin
               mstate = M_RUN; mmode = mpend; m_done = 1'b1; mp = 0; mactive = 1'b1;
            end else begin
               swc++;
            end
         end
      endcase
   endtask

   task automatic push_exp();
      exp_t e;
      int   ht;
      e.ph = cur_ph; e.mode = mmode; e.err = m_err; e.done = m_done;
      e.ready = !in_rst && (mstate == M_RUN);
      if (in_rst || mstate == M_SW) begin
         e.h = 0; e.v = 0; e.de = 1'b0; e.frame = 1'b0; e.line = 1'b0;
         e.sw = !in_rst;
         e.hs = in_rst ? !HP[0] : !HP[mpend];
         e.vs = in_rst ? !VP[0] : !VP[mpend];
         mcnt = 0;
      end else begin
         ht = htot(mmode);
         e.h = mp % ht; e.v = mp / ht; e.sw = 1'b0;
         e.de = (e.h < HR[mmode]) && (e.v < VR[mmode]);
         e.hs = (e.h >= HR[mmode] + HF[mmode] && e.h < HR[mmode] + HF[mmode] + HSY[mmode]) ? HP[mmode] : !HP[mmode];
         e.vs = (e.v >= VR[mmode] + VF[mmode] && e.v < VR[mmode] + VF[mmode] + VSY[mmode]) ? VP[mmode] : !VP[mmode];
         e.frame = (mp == 0);
         e.line  = (e.h == 0);
         if (e.frame) mcnt = (mcnt + 1) % 65536;
      end
      e.cnt = mcnt;
      mready = e.ready;
      expq.push_back(e);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      if (!rst_n) model_reset();
      else model_step();
      push_exp();
   endtask

   task automatic run(input int n);
      repeat (n) cyc();
   endtask

   task automatic req(input logic [1:0] m);
      mode_in = m;
      mode_valid = 1'b1;
      cyc();
      mode_valid = 1'b0;
   endtask

   task automatic async_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      model_reset();
      push_exp();
   endtask

   task automatic wait_model(input int st, input int pos, input int limit);
      int i = 0;
      while (!(mstate == st && (pos < 0 || mp == pos)) && i < limit) begin
         cyc();
         i++;
      end
      if (!(mstate == st && (pos < 0 || mp == pos))) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_model: got state=%0d pos=%0d, required state=%0d pos=%0d within %0d cycles",
                  mstate, mp, st, pos, limit);
      end
   endtask

   // Monitor: compares every sampled cycle against the head of the expectation queue.
   exp_t me;
   logic ok;
   initial begin
      forever begin
         @(negedge clk);
         if (expq.size() != 0) begin
            me = expq.pop_front();
            ok = (int'(h) == me.h) && (int'(v) == me.v) && (de === me.de) && (hs === me.hs)
              && (vs === me.vs) && (frame === me.frame) && (line === me.line)
              && (int'(mode_out) == me.mode) && (mode_ready === me.ready) && (mode_err === me.err)
              && (mode_done === me.done) && (switching === me.sw);
`ifdef DISPLAY_TIMINGS_FRAME_CNT_EN
            ok = ok && (int'(frame_cnt) == me.cnt);
`endif
            n_checks++;
            if (!ok) begin
               n_fail++;
               $display("FAIL %s t=%0t got h=%0d v=%0d de=%b hs=%b vs=%b fr=%b ln=%b md=%0d rdy=%b err=%b dn=%b sw=%b | required h=%0d v=%0d de=%b hs=%b vs=%b fr=%b ln=%b md=%0d rdy=%b err=%b dn=%b sw=%b cnt=%0d",
                        PH[me.ph], $time, h, v, de, hs, vs, frame, line, mode_out, mode_ready, mode_err,
                        mode_done, switching, me.h, me.v, me.de, me.hs, me.vs, me.frame, me.line, me.mode,
                        me.ready, me.err, me.done, me.sw, me.cnt);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; mode_valid = 1'b0; mode_in = 2'd0;
      model_reset();
      mready = 1'b0;
      cur_ph = 0;
      run(3);
      rst_n = 1'b1;
      cur_ph = 1;
      run(2 * 120 + 7);
      cur_ph = 2;
      req(2'd3);
      run(20);
      cur_ph = 3;
      req(2'd0);
      run(20);
      cur_ph = 4;
      wait_model(M_RUN, 2 * 15 + 4, 200);
      req(2'd2);
      mode_in = 2'd1;
      mode_valid = 1'b1;
      run(5);
      mode_valid = 1'b0;
      wait_model(M_RUN, 0, 300);
      run(2 * 170 + 5);
      cur_ph = 5;
      req(2'd1);
      wait_model(M_SW, -1, 400);
      run(4);
      async_reset();
      run(2);
      rst_n = 1'b1;
      cur_ph = 6;
      run(130);
      for (int i = 0; i < 10 && expq.size() != 0; i++) @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
